// File: rtl/mem_stage_if.sv
// Handshake and data-return signals between the execute, memory and writeback stages.
// The slave modport is the memory stage's view; master is the surrounding pipeline.
interface mem_stage_if;
    logic         es_to_ms_valid;
    logic [157:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [154:0] ms_to_ws_bus;
    logic         data_ok;
    logic [31:0]  data_rdata;
    logic         flush;
    logic [41:0]  ms_fwd;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_ok, data_rdata, flush,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_ok, data_rdata, flush,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, waits for load data, aligns it and
// hands the result to writeback; flushed loads are drained in DROP until data returns.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  io
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, DROP} state_t;

    typedef struct packed {
        logic        at_delay_slot;
        logic [41:0] cp0_msg;
        logic [6:0]  exception;
        logic [31:0] badvaddr;
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ws_bus_t;

    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;
    localparam logic [2:0] LD_W  = 3'd5;

    function automatic logic is_load(input logic [2:0] t);
        return (t >= LD_B) && (t <= LD_W);
    endfunction

    state_t       state, state_nx;
    logic         ms_valid;
    logic [157:0] pl;
    logic [31:0]  rdata_r;

    ws_bus_t      pl_f, out_f;
    logic [2:0]   pl_ld;
    logic         pl_exc;
    logic         pl_load_wb;

    logic         in_wait;
    logic         ms_ready_go;
    logic         accept;
    logic         leave;

    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;
    logic [31:0]  ld_data;

    assign pl_f       = pl[154:0];
    assign pl_ld      = pl[157:155];
    assign pl_exc     = (pl_f.exception != 7'd0);
    // An excepting load never issued a read, so its result field is passed through.
    assign pl_load_wb = is_load(pl_ld) && !pl_exc;

    assign in_wait = is_load(io.es_to_ms_bus[157:155]) && (io.es_to_ms_bus[111:105] == 7'd0);

    assign ms_ready_go = ms_valid && ((state == IDLE) || (state == DONE));
    assign io.ms_allowin = (!ms_valid || (ms_ready_go && io.ws_allowin)) && (state != DROP);
    assign accept = io.es_to_ms_valid && io.ms_allowin && !io.flush;
    assign leave  = ms_ready_go && io.ws_allowin;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && in_wait) state_nx = WAIT;
            WAIT: begin
                if (io.flush)        state_nx = io.data_ok ? IDLE : DROP;
                else if (io.data_ok) state_nx = DONE;
            end
            DONE: begin
                if (io.flush)    state_nx = IDLE;
                else if (leave)  state_nx = (accept && in_wait) ? WAIT : IDLE;
            end
            DROP: if (io.data_ok) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ms_valid <= 1'b0;
            pl       <= '0;
            rdata_r  <= '0;
        end else begin
            state <= state_nx;
            if (io.flush)    ms_valid <= 1'b0;
            else if (accept) ms_valid <= 1'b1;
            else if (leave)  ms_valid <= 1'b0;
            if (accept) pl <= io.es_to_ms_bus;
            if ((state == WAIT) && io.data_ok && !io.flush) rdata_r <= io.data_rdata;
        end
    end

    always_comb begin
        case (pl_f.result[1:0])
            2'd0:    ld_byte = rdata_r[7:0];
            2'd1:    ld_byte = rdata_r[15:8];
            2'd2:    ld_byte = rdata_r[23:16];
            default: ld_byte = rdata_r[31:24];
        endcase
        ld_half = pl_f.result[1] ? rdata_r[31:16] : rdata_r[15:0];
        case (pl_ld)
            LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   ld_data = {24'd0, ld_byte};
            LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LD_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = rdata_r;
        endcase
    end

    always_comb begin
        out_f        = pl_f;
        out_f.result = pl_load_wb ? ld_data : pl_f.result;
        out_f.gr_we  = pl_exc ? 4'd0 : pl_f.gr_we;
    end

    assign io.ms_to_ws_valid = ms_ready_go && !io.flush;
    assign io.ms_to_ws_bus   = out_f;
    assign io.ms_fwd = {ms_valid && (state == WAIT),
                        ms_valid ? out_f.gr_we : 4'd0,
                        pl_f.dest,
                        out_f.result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage, checked against a transaction-level model.
module tb_mem_stage;

    logic clk;
    logic reset;
    mem_stage_if intf();

    int n_chk = 0;
    int n_err = 0;

    mem_stage dut (.clk(clk), .reset(reset), .io(intf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [157:0] obs, input logic [157:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [157:0] mk(input logic [2:0] ld, input logic [6:0] ex,
                                        input logic [3:0] we, input logic [4:0] dest,
                                        input logic [31:0] res, input logic [31:0] pc);
        logic [157:0] b;
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b[157:155] = ld;
        b[111:105] = ex;
        b[72:69]   = we;
        b[68:64]   = dest;
        b[63:32]   = res;
        b[31:0]    = pc;
        return b;
    endfunction

    // Expected writeback payload computed from the load rules with plain arithmetic.
    function automatic logic [154:0] model(input logic [157:0] ib, input logic [31:0] rd);
        logic [154:0] o;
        int unsigned t, a, w, b, h, res;
        logic [6:0] ex;
        o   = ib[154:0];
        t   = ib[157:155];
        ex  = ib[111:105];
        a   = ib[33:32];
        w   = rd;
        b   = (w >> (8 * a)) % 256;
        h   = (w >> (16 * (a / 2))) % 65536;
        res = ib[63:32];
        if (ex == 0) begin
            case (t)
                1: res = (b < 128) ? b : b + 32'hFFFF_FF00;
                2: res = b;
                3: res = (h < 32768) ? h : h + 32'hFFFF_0000;
                4: res = h;
                5: res = w;
                default: res = ib[63:32];
            endcase
        end
        o[63:32] = res;
        if (ex != 0) o[72:69] = 4'd0;
        return o;
    endfunction

    // One instruction end to end: issue, optional data return, optional stall, drain.
    task automatic do_txn(input string tag, input logic [157:0] ib, input int lat,
                          input logic [31:0] rd, input int stall);
        logic [154:0] exp;
        logic [154:0] obs;
        logic [41:0]  efwd, ofwd;
        logic waits, mask;
        exp   = model(ib, rd);
        waits = (ib[157:155] >= 3'd1) && (ib[157:155] <= 3'd5) && (ib[111:105] == 7'd0);
        mask  = (ib[157:155] >= 3'd1) && (ib[157:155] <= 3'd5) && !waits;
        if (mask) exp[63:32] = '0;
        efwd = {1'b0, exp[72:69], exp[68:64], exp[63:32]};
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus   = ib;
        intf.ws_allowin     = 1'b1;
        #1;
        chk({tag, ".allowin"}, 158'(intf.ms_allowin), 158'(1));
        @(negedge clk);
        intf.es_to_ms_valid = 1'b0;
        intf.es_to_ms_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        #1;
        if (waits) begin
            for (int i = 0; i < lat; i++) begin
                chk({tag, ".blocking"}, 158'(intf.ms_fwd[41]), 158'(1));
                chk({tag, ".wait_valid"}, 158'(intf.ms_to_ws_valid), 158'(0));
                @(negedge clk);
                #1;
            end
            intf.data_ok    = 1'b1;
            intf.data_rdata = rd;
            #1;
            chk({tag, ".dok_valid"}, 158'(intf.ms_to_ws_valid), 158'(0));
            @(negedge clk);
            intf.data_ok    = 1'b0;
            intf.data_rdata = $urandom;
        end
        for (int i = 0; i < stall; i++) begin
            intf.ws_allowin = 1'b0;
            #1;
            obs = intf.ms_to_ws_bus;
            if (mask) obs[63:32] = '0;
            chk({tag, ".stall_valid"}, 158'(intf.ms_to_ws_valid), 158'(1));
            chk({tag, ".stall_allowin"}, 158'(intf.ms_allowin), 158'(0));
            chk({tag, ".stall_bus"}, 158'(obs), 158'(exp));
            @(negedge clk);
        end
        intf.ws_allowin = 1'b1;
        #1;
        obs  = intf.ms_to_ws_bus;
        ofwd = intf.ms_fwd;
        if (mask) begin
            obs[63:32] = '0;
            ofwd[31:0] = '0;
        end
        chk({tag, ".valid"}, 158'(intf.ms_to_ws_valid), 158'(1));
        chk({tag, ".bus"}, 158'(obs), 158'(exp));
        chk({tag, ".fwd"}, 158'(ofwd), 158'(efwd));
        @(negedge clk);
        #1;
        chk({tag, ".empty"}, 158'(intf.ms_to_ws_valid), 158'(0));
        chk({tag, ".free"}, 158'(intf.ms_allowin), 158'(1));
    endtask

    initial begin
        logic [157:0] b1, b2;
        logic [154:0] e1, e2;
        reset = 1'b1;
        intf.es_to_ms_valid = 1'b0;
        intf.es_to_ms_bus   = '0;
        intf.ws_allowin     = 1'b1;
        intf.data_ok        = 1'b0;
        intf.data_rdata     = '0;
        intf.flush          = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset.valid", 158'(intf.ms_to_ws_valid), 158'(0));
        chk("reset.allowin", 158'(intf.ms_allowin), 158'(1));
        chk("reset.fwd", 158'(intf.ms_fwd), 158'(0));

        // stray data_ok while idle must be ignored
        @(negedge clk);
        intf.data_ok = 1'b1;
        intf.data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        intf.data_ok = 1'b0;
        #1;
        chk("idle_dok.valid", 158'(intf.ms_to_ws_valid), 158'(0));
        chk("idle_dok.allowin", 158'(intf.ms_allowin), 158'(1));

        do_txn("add", mk(3'd0, 7'd0, 4'hF, 5'd5, 32'h1234_5678, 32'hBFC0_0000), 0, 32'h0, 0);
        do_txn("lb", mk(3'd1, 7'd0, 4'hF, 5'd7, 32'h0000_1003, 32'hBFC0_0004), 2, 32'h80FF_0000, 0);
        do_txn("lhu", mk(3'd4, 7'd0, 4'h3, 5'd9, 32'h0000_2002, 32'hBFC0_0008), 1, 32'hBEEF_1234, 3);
        do_txn("lw_exc", mk(3'd5, 7'h02, 4'hF, 5'd3, 32'h0000_3001, 32'hBFC0_000C), 0, 32'h0, 0);
        do_txn("ld7", mk(3'd7, 7'd0, 4'h1, 5'd4, 32'hCAFE_0001, 32'hBFC0_0010), 0, 32'h0, 0);

        // flush in WAIT, data returns two cycles later
        @(negedge clk);
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus   = mk(3'd5, 7'd0, 4'hF, 5'd2, 32'h0000_4000, 32'hBFC0_0014);
        @(negedge clk);
        intf.es_to_ms_valid = 1'b0;
        intf.flush = 1'b1;
        #1;
        chk("flush.valid", 158'(intf.ms_to_ws_valid), 158'(0));
        @(negedge clk);
        intf.flush = 1'b0;
        intf.es_to_ms_valid = 1'b1;
        #1;
        chk("drop.allowin", 158'(intf.ms_allowin), 158'(0));
        chk("drop.valid", 158'(intf.ms_to_ws_valid), 158'(0));
        @(negedge clk);
        intf.data_ok = 1'b1;
        intf.data_rdata = 32'h1111_2222;
        #1;
        chk("drop_dok.allowin", 158'(intf.ms_allowin), 158'(0));
        @(negedge clk);
        intf.data_ok = 1'b0;
        intf.es_to_ms_valid = 1'b0;
        #1;
        chk("drop_exit.allowin", 158'(intf.ms_allowin), 158'(1));
        chk("drop_exit.valid", 158'(intf.ms_to_ws_valid), 158'(0));

        // flush blocks capture of an arriving instruction
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus   = mk(3'd0, 7'd0, 4'hF, 5'd1, 32'h5555_AAAA, 32'hBFC0_0018);
        intf.flush = 1'b1;
        @(negedge clk);
        intf.es_to_ms_valid = 1'b0;
        intf.flush = 1'b0;
        #1;
        chk("flush_in.valid", 158'(intf.ms_to_ws_valid), 158'(0));
        chk("flush_in.fwd_we", 158'(intf.ms_fwd[40:37]), 158'(0));

        // back-to-back loads with one-cycle data latency
        b1 = mk(3'd5, 7'd0, 4'hF, 5'd10, 32'h0000_5000, 32'hBFC0_0020);
        b2 = mk(3'd5, 7'd0, 4'hF, 5'd11, 32'h0000_5004, 32'hBFC0_0024);
        e1 = model(b1, 32'hA1A2_A3A4);
        e2 = model(b2, 32'hB1B2_B3B4);
        @(negedge clk);
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus = b1;
        @(negedge clk);
        intf.es_to_ms_valid = 1'b0;
        intf.data_ok = 1'b1;
        intf.data_rdata = 32'hA1A2_A3A4;
        @(negedge clk);
        intf.data_ok = 1'b0;
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus = b2;
        #1;
        chk("b2b.first_valid", 158'(intf.ms_to_ws_valid), 158'(1));
        chk("b2b.first_bus", 158'(intf.ms_to_ws_bus), 158'(e1));
        chk("b2b.first_allowin", 158'(intf.ms_allowin), 158'(1));
        @(negedge clk);
        intf.es_to_ms_valid = 1'b0;
        intf.data_ok = 1'b1;
        intf.data_rdata = 32'hB1B2_B3B4;
        #1;
        chk("b2b.second_block", 158'(intf.ms_fwd[41]), 158'(1));
        @(negedge clk);
        intf.data_ok = 1'b0;
        #1;
        chk("b2b.second_valid", 158'(intf.ms_to_ws_valid), 158'(1));
        chk("b2b.second_bus", 158'(intf.ms_to_ws_bus), 158'(e2));
        @(negedge clk);

        // reset in DROP together with data_ok and flush
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus = mk(3'd3, 7'd0, 4'h3, 5'd6, 32'h0000_6002, 32'hBFC0_0028);
        @(negedge clk);
        intf.es_to_ms_valid = 1'b0;
        intf.flush = 1'b1;
        @(negedge clk);
        intf.flush = 1'b0;
        #1;
        chk("rst_drop.pre_allowin", 158'(intf.ms_allowin), 158'(0));
        reset = 1'b1;
        intf.data_ok = 1'b1;
        intf.flush = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        intf.flush = 1'b0;
        intf.data_ok = 1'b0;
        #1;
        chk("rst_drop.allowin", 158'(intf.ms_allowin), 158'(1));
        chk("rst_drop.fwd", 158'(intf.ms_fwd), 158'(0));
        intf.data_ok = 1'b1;
        @(negedge clk);
        intf.data_ok = 1'b0;
        #1;
        chk("rst_drop.late_dok", 158'(intf.ms_allowin), 158'(1));
        chk("rst_drop.late_valid", 158'(intf.ms_to_ws_valid), 158'(0));

        for (int n = 0; n < 40; n++) begin
            logic [6:0] ex;
            ex = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            do_txn("rand", mk(3'($urandom_range(0, 7)), ex, 4'($urandom), 5'($urandom),
                              $urandom, $urandom),
                   $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: es_to_ms_valid  in  1  upstream instruction valid.
REQ-004 SHALL have port: es_to_ms_bus  in  158  upstream payload; field map below.
- [157:155] ld_type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6 and 7 are treated as none.
- [154:0] carries the downstream fields.
- [63:32] holds the ALU result, or the byte address for loads.
REQ-005 SHALL have port: ms_allowin  out  1  stage can accept an instruction this cycle.
REQ-006 SHALL have port: ws_allowin  in  1  downstream can accept.
REQ-007 SHALL have port: ms_to_ws_valid  out  1  downstream payload valid.
REQ-008 SHALL have port: ms_to_ws_bus  out  155  downstream payload, field map below.
- [154] at_delay_slot
- [153:112] cp0_msg
- [111:105] exception
- [104:73] badvaddr
- [72:69] gr_we
- [68:64] dest
- [63:32] result
- [31:0] pc
REQ-009 SHALL have port: data_ok  in  1  one-cycle pulse: load read data returned.
REQ-010 SHALL have port: data_rdata  in  32  load read word; valid only when data_ok=1.
REQ-011 SHALL have port: flush  in  1  writeback exception/eret; kills the in-stage instruction.
REQ-012 SHALL have port: ms_fwd  out  42  forwarding bus {blocking[41], we[40:37], dest[36:32], data[31:0]}.

Function
REQ-013 SHALL hold one instruction in payload register pl; ms_valid marks pl occupied.
REQ-014 SHALL implement 4-state FSM {IDLE, WAIT, DONE, DROP}:
- IDLE: no load outstanding.
- WAIT: load issued, awaiting data_ok.
- DONE: load data captured.
- DROP: killed load still awaiting data_ok.
REQ-015 SHALL latch es_to_ms_bus into pl when es_to_ms_valid && ms_allowin.
REQ-016 SHALL enter WAIT on that same edge iff ld_type is in 1..5 and exception field == 0; otherwise SHALL stay in IDLE.
REQ-017 SHALL in WAIT capture data_rdata into rdata_r on data_ok and move to DONE.
REQ-018 SHALL define ms_ready_go = ms_valid && (state==IDLE || state==DONE).
- WAIT with data_ok=1 counts as not ready that cycle.
- The earliest a load can pass downstream is one cycle after data_ok.
REQ-019 SHALL drive ms_to_ws_valid = ms_ready_go && !flush.
REQ-020 SHALL drive ms_allowin = (!ms_valid || (ms_ready_go && ws_allowin)) && state!=DROP.
REQ-021 SHALL return to IDLE from DONE when the instruction leaves (ws_allowin && ms_ready_go) and no new load enters.
- If a new load enters on the same edge, SHALL go to WAIT.
REQ-022 SHALL clear ms_valid when the instruction leaves and none enters.
REQ-023 SHALL align load data using a = result[1:0]:
- LB: sign-extend byte a.
- LBU: zero-extend byte a.
- LH: sign-extend half a[1].
- LHU: zero-extend half a[1].
- LW: full word.
REQ-024 SHALL place aligned load data in ms_to_ws_bus[63:32] for loads; all other fields SHALL pass through unchanged.
REQ-025 SHALL force gr_we output to 0 when exception field != 0.
REQ-026 SHALL on flush clear ms_valid on the next edge, from any state.
REQ-027 SHALL on flush in WAIT without data_ok go to DROP; with data_ok it SHALL go to IDLE.
REQ-028 SHALL leave DROP on data_ok, discarding data_rdata, and go to IDLE; ms_allowin=0 throughout DROP.
REQ-029 SHALL ignore data_ok in IDLE and DONE; a protocol violation there SHALL cause no state change.
REQ-030 SHALL on flush ignore es_to_ms_valid that same cycle; no capture occurs.
REQ-031 SHALL drive ms_fwd as follows:
- we = ms_valid ? out gr_we : 0.
- dest = pl dest.
- data = out result.
- blocking = ms_valid && state==WAIT.

Reset
REQ-032 SHALL on reset set state=IDLE, ms_valid=0, pl=0 and rdata_r=0.
REQ-033 SHALL after reset show ms_to_ws_valid=0, ms_allowin=1 and ms_fwd=0.
REQ-034 SHALL let reset override flush, data_ok and mid-DROP state; any later data_ok SHALL be ignored.

Verification
REQ-035 SHALL cover non-load passthrough:
- Stimulus: ADD, result 0x12345678, dest 5, gr_we 0xF, ws_allowin=1.
- Response: next cycle ms_to_ws_valid=1, bus[63:32]=0x12345678, ms_fwd.we=0xF.
REQ-036 SHALL cover LB with latency:
- Stimulus: addr 0x...03, data_ok two cycles later with rdata 0x80FF_0000.
- Response: blocking=1 for 2 cycles, then result=0xFFFFFF80.
REQ-037 SHALL cover LHU backpressure:
- Stimulus: addr 0x...02, rdata 0xBEEF1234, ws_allowin=0 for 3 cycles.
- Response: DONE held, ms_allowin=0, result 0x0000BEEF on release.
REQ-038 SHALL cover flush in WAIT:
- Stimulus: flush, then data_ok 2 cycles later.
- Response: DROP, ms_allowin=0 until data_ok, then IDLE; no ms_to_ws_valid pulse.
REQ-039 SHALL cover an excepting load:
- Stimulus: exception=0x02, ld_type=LW.
- Response: no WAIT state, forwarded next cycle with gr_we=0.
REQ-040 SHALL cover back-to-back loads:
- Stimulus: LW then LW, each data_ok at 1-cycle latency.
- Response: both delivered in order, no bubble beyond the data_ok wait.
